reg_file_wr_ctrl: RTL and testbench

Write-port controller for the two-entry, 16-bit register file. It arbitrates write requests from two independent requesters and keeps a shadow copy of the register contents. It drives the file's packed full-overwrite input bus, so every cycle's load carries all prior writes plus newly accepted ones. It sits directly in front of the register file; reads continue to use the file's own read port.

---
 rtl/reg_file_wr_ctrl_pkg.sv | 21 ++
 rtl/reg_file_wr_ctrl_if.sv | 15 +
 rtl/reg_file_be_merge.sv | 20 ++
 rtl/reg_file_wr_ctrl.sv | 79 +++++++
 tb/tb_reg_file_wr_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/reg_file_wr_ctrl_pkg.sv
// Shared constants and the shadow-to-load-bus packing used by the register file write path.
// Entry 0 occupies the most significant slice of the bus.
package reg_file_wr_ctrl_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned N_ENTRY = 2;
    localparam int unsigned N_BYTE  = DATA_W / 8;
    localparam int unsigned BUS_W   = N_ENTRY * DATA_W;

    typedef logic [DATA_W-1:0] word_t;

    function automatic logic [BUS_W-1:0] pack_shadow(input word_t shadow [N_ENTRY]);
        logic [BUS_W-1:0] bus;
        bus = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            bus[(N_ENTRY-1-i)*DATA_W +: DATA_W] = shadow[i];
        end
        return bus;
    endfunction

endpackage

// File: rtl/reg_file_wr_ctrl_if.sv
// One requester's write channel: valid/ready handshake with address, data and byte enables.
// The requester drives the master modport; the controller takes the slave modport.
interface reg_file_wr_ctrl_if;
    import reg_file_wr_ctrl_pkg::*;

    logic              valid;
    logic              ready;
    logic              addr;
    word_t             data;
    logic [N_BYTE-1:0] be;

    modport master (output valid, output addr, output data, output be, input ready);
    modport slave  (input valid, input addr, input data, input be, output ready);

endinterface

// File: rtl/reg_file_be_merge.sv
// Byte-lane merge: lanes with their enable set take the new data, the rest keep the old word.
module reg_file_be_merge
    import reg_file_wr_ctrl_pkg::*;
(
    input  word_t             old_i,
    input  word_t             new_i,
    input  logic [N_BYTE-1:0] be_i,
    output word_t             merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < N_BYTE; b++) begin
            if (be_i[b]) begin
                merged_o[b*8 +: 8] = new_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/reg_file_wr_ctrl.sv
// Two-requester write controller for the 2x16 register file: arbitrates writes, keeps a
// shadow copy and drives the file's full-overwrite load bus from registered state.
module reg_file_wr_ctrl
    import reg_file_wr_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    reg_file_wr_ctrl_if.slave     req0,
    reg_file_wr_ctrl_if.slave     req1,
    output logic [BUS_W-1:0]      r_in,
    output logic [CNT_W-1:0]      coll_cnt
);

    word_t             shadow_q [N_ENTRY];
    word_t             shadow_d [N_ENTRY];
    logic [BUS_W-1:0]  r_in_q, r_in_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  coll_cnt_q, coll_cnt_d;

    logic  collide;
    logic  gnt0, gnt1;
    word_t merged0, merged1;

    reg_file_be_merge u_merge0 (
        .old_i    (shadow_q[req0.addr]),
        .new_i    (req0.data),
        .be_i     (req0.be),
        .merged_o (merged0)
    );

    reg_file_be_merge u_merge1 (
        .old_i    (shadow_q[req1.addr]),
        .new_i    (req1.data),
        .be_i     (req1.be),
        .merged_o (merged1)
    );

    always_comb begin
        collide = req0.valid && req1.valid && (req0.addr == req1.addr);
        // On a collision only the requester rr_ptr points at is granted.
        gnt0 = !reset && req0.valid && (!collide || !rr_ptr_q);
        gnt1 = !reset && req1.valid && (!collide || rr_ptr_q);

        shadow_d = shadow_q;
        if (gnt0) shadow_d[req0.addr] = merged0;
        if (gnt1) shadow_d[req1.addr] = merged1;

        rr_ptr_d   = rr_ptr_q;
        coll_cnt_d = coll_cnt_q;
        if (collide) begin
            rr_ptr_d = ~rr_ptr_q;
            if (coll_cnt_q != '1) coll_cnt_d = coll_cnt_q + 1'b1;
        end

        r_in_d = pack_shadow(shadow_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRY; i++) shadow_q[i] <= '0;
            r_in_q     <= '0;
            rr_ptr_q   <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            r_in_q     <= r_in_d;
            rr_ptr_q   <= rr_ptr_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign req0.ready = gnt0;
    assign req1.ready = gnt1;
    assign r_in       = r_in_q;
    assign coll_cnt   = coll_cnt_q;

endmodule

// File: tb/tb_reg_file_wr_ctrl.sv
// Directed and randomized bench for reg_file_wr_ctrl against a behavioural write-port model,
// including a register file that loads r_in every cycle.
module tb_reg_file_wr_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] r_in;
    logic [7:0]  coll_cnt;
    logic [31:0] rf_q;

    int n_vec  = 0;
    int n_fail = 0;

    logic [15:0] m_sh [2];
    bit          m_ptr;
    int          m_cnt;
    bit          rf_known;

    reg_file_wr_ctrl_if req0_if ();
    reg_file_wr_ctrl_if req1_if ();

    reg_file_wr_ctrl #(.CNT_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .req0     (req0_if),
        .req1     (req1_if),
        .r_in     (r_in),
        .coll_cnt (coll_cnt)
    );

    always #5 clock = ~clock;

    // Register file: full overwrite from the load bus on every edge.
    always_ff @(posedge clock) rf_q <= r_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_cycle(input bit rst,
                            input bit v0, input bit a0, input logic [15:0] d0, input logic [1:0] be0,
                            input bit v1, input bit a1, input logic [15:0] d1, input logic [1:0] be1);
        bit          g0, g1, coll;
        logic [31:0] prev_rin;
        reset         = rst;
        req0_if.valid = v0; req0_if.addr = a0; req0_if.data = d0; req0_if.be = be0;
        req1_if.valid = v1; req1_if.addr = a1; req1_if.data = d1; req1_if.be = be1;

        coll = v0 && v1 && (a0 == a1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (coll) begin
                if (m_ptr) g1 = 1'b1;
                else       g0 = 1'b1;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end

        @(negedge clock);
        chk("ready0", {31'd0, req0_if.ready}, {31'd0, g0});
        chk("ready1", {31'd0, req1_if.ready}, {31'd0, g1});
        prev_rin = {m_sh[0], m_sh[1]};

        @(posedge clock);
        if (rst) begin
            m_sh[0] = '0;
            m_sh[1] = '0;
            m_ptr   = 1'b0;
            m_cnt   = 0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (g0 && be0[b]) m_sh[a0][b*8 +: 8] = d0[b*8 +: 8];
                if (g1 && be1[b]) m_sh[a1][b*8 +: 8] = d1[b*8 +: 8];
            end
            if (coll) begin
                m_ptr = !m_ptr;
                m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            end
        end

        #1;
        chk("r_in", r_in, {m_sh[0], m_sh[1]});
        chk("coll_cnt", {24'd0, coll_cnt}, m_cnt);
        if (rf_known) chk("rf_read", rf_q, prev_rin);
        rf_known = 1'b1;
    endtask

    task automatic idle();
        do_cycle(0, 0, 0, 16'h0, 2'b00, 0, 0, 16'h0, 2'b00);
    endtask

    initial begin
        m_sh[0] = '0; m_sh[1] = '0; m_ptr = 0; m_cnt = 0; rf_known = 0;
        reset = 1'b1;
        req0_if.valid = 0; req0_if.addr = 0; req0_if.data = '0; req0_if.be = '0;
        req1_if.valid = 0; req1_if.addr = 0; req1_if.data = '0; req1_if.be = '0;
        @(posedge clock); #1;

        // Reset with both requesting: neither granted, everything cleared.
        do_cycle(1, 1, 0, 16'hDEAD, 2'b11, 1, 0, 16'hBEEF, 2'b11);
        chk("rst_r_in", r_in, 32'h0);
        chk("rst_cnt", {24'd0, coll_cnt}, 32'h0);

        // Single write, then file read one edge later.
        do_cycle(0, 1, 0, 16'hA5A5, 2'b11, 0, 0, 16'h0, 2'b00);
        chk("a5_r_in", r_in, 32'hA5A5_0000);
        idle();
        chk("a5_rf", rf_q[31:16], 32'hA5A5);

        // Dual write to different entries.
        do_cycle(0, 1, 0, 16'h1111, 2'b11, 1, 1, 16'h2222, 2'b11);
        chk("dual_r_in", r_in, 32'h1111_2222);
        chk("dual_cnt", {24'd0, coll_cnt}, 32'h0);

        // Three collisions on entry 1: req0, req1, req0; then req1 alone with its new data.
        do_cycle(0, 1, 1, 16'h3333, 2'b11, 1, 1, 16'h4444, 2'b11);
        chk("col1_e1", r_in[15:0], 32'h3333);
        do_cycle(0, 1, 1, 16'h3333, 2'b11, 1, 1, 16'h4444, 2'b11);
        chk("col2_e1", r_in[15:0], 32'h4444);
        do_cycle(0, 1, 1, 16'h3333, 2'b11, 1, 1, 16'h5555, 2'b11);
        chk("col3_e1", r_in[15:0], 32'h3333);
        do_cycle(0, 0, 1, 16'h0, 2'b00, 1, 1, 16'h5555, 2'b11);
        chk("col_final_e1", r_in[15:0], 32'h5555);
        chk("col_cnt3", {24'd0, coll_cnt}, 32'd3);

        // Byte-enable merges.
        do_cycle(0, 1, 0, 16'hFFFF, 2'b11, 0, 0, 16'h0, 2'b00);
        do_cycle(0, 0, 0, 16'h0, 2'b00, 1, 0, 16'h0012, 2'b01);
        chk("be01_e0", r_in[31:16], 32'hFF12);
        do_cycle(0, 0, 0, 16'h0, 2'b00, 1, 0, 16'hABCD, 2'b00);
        chk("be00_e0", r_in[31:16], 32'hFF12);

        // Reset mid-stream, then first collision goes to req0.
        do_cycle(1, 1, 1, 16'h7777, 2'b11, 1, 1, 16'h8888, 2'b11);
        chk("mid_rst_r_in", r_in, 32'h0);
        do_cycle(0, 1, 1, 16'h7777, 2'b11, 1, 1, 16'h8888, 2'b11);
        chk("post_rst_e1", r_in[15:0], 32'h7777);

        // Saturate the collision counter and keep alternating past it.
        for (int i = 0; i < 256; i++) begin
            do_cycle(0, 1, 0, 16'(i), 2'b11, 1, 0, 16'(i + 1000), 2'b11);
        end
        chk("sat_cnt", {24'd0, coll_cnt}, 32'hFF);
        do_cycle(0, 1, 0, 16'h0AAA, 2'b11, 1, 0, 16'h0BBB, 2'b11);
        chk("sat_hold", {24'd0, coll_cnt}, 32'hFF);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 31) == 0),
                     1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom),
                     1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
